// File: rtl/pipelined_align_shifter_if.sv
// Handshake bundle for the pipelined alignment shifter: input beat
// (operand, amount, op, tag) and output result, each with valid/ready.
interface pipelined_align_shifter_if #(
  parameter int WIDTH = 24,
  parameter int AMT_W = 8,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_sticky, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_sticky, out_tag
  );
endinterface

// File: rtl/pipelined_align_shifter.sv
// Pipelined barrel shifter: LSR / ASR / LSL by a variable amount, built as
// a cascade of 2:1 mux stages (stage k shifts by 2^k), with a register after
// every REG_EVERY mux stages. Right shifts accumulate a sticky bit from every
// bit pushed out of the LSB end. Elastic valid/ready pipeline; bubbles collapse.
module pipelined_align_shifter #(
  parameter int WIDTH     = 24,
  parameter int AMT_W     = 8,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic clk,
  input  logic rst_n,
  pipelined_align_shifter_if.slave bus
);

  localparam int L = (AMT_W + REG_EVERY - 1) / REG_EVERY;

  localparam logic [1:0] OP_ASR = 2'b01;
  localparam logic [1:0] OP_LSL = 2'b10;

  // One mux stage of shift 2^k. Returns {sticky, data}. Anything other than
  // ASR/LSL (including the reserved code) behaves as LSR.
  function automatic logic [WIDTH:0] shift_stage(
    input logic [WIDTH-1:0] d,
    input logic             st,
    input logic [1:0]       op,
    input int               k
  );
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] lost;
    logic             fill;
    logic             big;
    int               sh;
    fill = (op == OP_ASR) && d[WIDTH-1];
    big  = (k >= 31) || ((1 << k) >= WIDTH);
    sh   = big ? 0 : (1 << k);
    if (op == OP_LSL) begin
      res = big ? '0 : (d << sh);
      return {st, res};
    end
    if (big) begin
      res = fill ? '1 : '0;
      return {st | (|d), res};
    end
    res = d >> sh;
    if (fill) res = res | ~({WIDTH{1'b1}} >> sh);
    lost = d & ~({WIDTH{1'b1}} << sh);
    return {st | (|lost), res};
  endfunction

  logic             v_q   [L];
  logic [WIDTH-1:0] d_q   [L];
  logic [AMT_W-1:0] amt_q [L];
  logic [1:0]       op_q  [L];
  logic             st_q  [L];
  logic [TAG_W-1:0] tag_q [L];

  logic             src_v   [L];
  logic [WIDTH-1:0] src_d   [L];
  logic [AMT_W-1:0] src_amt [L];
  logic [1:0]       src_op  [L];
  logic             src_st  [L];
  logic [TAG_W-1:0] src_tag [L];

  logic [WIDTH-1:0] nd  [L];
  logic             nst [L];

  logic [L-1:0]     ld;

  // Feed each register stage from its predecessor (stage 0 from the input port).
  always_comb begin
    src_v[0]   = bus.in_valid;
    src_d[0]   = bus.in_data;
    src_amt[0] = bus.in_amt;
    src_op[0]  = bus.in_op;
    src_st[0]  = 1'b0;
    src_tag[0] = bus.in_tag;
    for (int s = 1; s < L; s++) begin
      src_v[s]   = v_q[s-1];
      src_d[s]   = d_q[s-1];
      src_amt[s] = amt_q[s-1];
      src_op[s]  = op_q[s-1];
      src_st[s]  = st_q[s-1];
      src_tag[s] = tag_q[s-1];
    end
  end

  // Mux cascade in front of each register: stages s*REG_EVERY .. s*REG_EVERY+REG_EVERY-1.
  always_comb begin
    logic [WIDTH-1:0] cd;
    logic             cst;
    logic [WIDTH:0]   r;
    logic [AMT_W-1:0] a_sh;
    int               k;
    cd   = '0;
    cst  = 1'b0;
    r    = '0;
    a_sh = '0;
    k    = 0;
    for (int s = 0; s < L; s++) begin
      cd  = src_d[s];
      cst = src_st[s];
      for (int j = 0; j < REG_EVERY; j++) begin
        k    = s * REG_EVERY + j;
        a_sh = src_amt[s] >> k;
        if (k < AMT_W && a_sh[0]) begin
          r   = shift_stage(cd, cst, src_op[s], k);
          cd  = r[WIDTH-1:0];
          cst = r[WIDTH];
        end
      end
      nd[s]  = cd;
      nst[s] = cst;
    end
  end

  // Load enables ripple back from out_ready: a stage loads if empty or draining.
  always_comb begin
    logic chain;
    chain = bus.out_ready;
    ld    = '0;
    for (int s = L - 1; s >= 0; s--) begin
      chain = !v_q[s] | chain;
      ld[s] = chain;
    end
  end

  // Pipeline registers; payload only captured for valid beats to keep idle outputs quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < L; s++) begin
        v_q[s]   <= 1'b0;
        d_q[s]   <= '0;
        amt_q[s] <= '0;
        op_q[s]  <= '0;
        st_q[s]  <= 1'b0;
        tag_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < L; s++) begin
        if (ld[s]) begin
          v_q[s] <= src_v[s];
          if (src_v[s]) begin
            d_q[s]   <= nd[s];
            amt_q[s] <= src_amt[s];
            op_q[s]  <= src_op[s];
            st_q[s]  <= nst[s];
            tag_q[s] <= src_tag[s];
          end
        end
      end
    end
  end

  assign bus.in_ready   = ld[0];
  assign bus.out_valid  = v_q[L-1];
  assign bus.out_data   = d_q[L-1];
  assign bus.out_sticky = st_q[L-1];
  assign bus.out_tag    = tag_q[L-1];

endmodule

// File: tb/tb_pipelined_align_shifter.sv
// Directed and streaming checks for pipelined_align_shifter (WIDTH=24, AMT_W=8,
// REG_EVERY=2, TAG_W=4, latency 4).
module tb_pipelined_align_shifter;

  localparam int WIDTH = 24;
  localparam int AMT_W = 8;
  localparam int TAG_W = 4;
  localparam int LAT   = 4;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nfail;

  pipelined_align_shifter_if #(.WIDTH(WIDTH), .AMT_W(AMT_W), .TAG_W(TAG_W)) bus ();

  pipelined_align_shifter #(
    .WIDTH(WIDTH), .AMT_W(AMT_W), .REG_EVERY(2), .TAG_W(TAG_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  amt;
    logic [23:0] d;
    logic [23:0] exp_d;
    logic        exp_s;
  } vec_t;

  typedef struct {
    logic [23:0] d;
    logic        s;
    logic [3:0]  t;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Whole-amount reference, computed directly rather than stage by stage.
  function automatic logic [24:0] model(input logic [1:0] op, input logic [7:0] amt,
                                        input logic [23:0] d);
    int          a;
    logic [23:0] r;
    logic        s;
    a = int'(amt);
    if (op == 2'b10) begin
      r = (a >= 24) ? 24'h0 : (d << a);
      s = 1'b0;
    end else if (a >= 24) begin
      r = (op == 2'b01 && d[23]) ? 24'hFFFFFF : 24'h0;
      s = |d;
    end else begin
      r = (op == 2'b01) ? 24'($signed(d) >>> a) : (d >> a);
      s = |(d & ((24'd1 << a) - 24'd1));
    end
    return {s, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty pipe with out_ready=1; checks latency and result.
  task automatic run_vec(input string nm, input logic [1:0] op, input logic [7:0] amt,
                         input logic [23:0] d, input logic [3:0] tag,
                         input logic [23:0] exp_d, input logic exp_s);
    int lat;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_amt    = amt;
    bus.in_data   = d;
    bus.in_tag    = tag;
    bus.out_ready = 1'b1;
    #1;
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.out_valid) begin
        lat = c;
        break;
      end
      step();
    end
    chk({nm, " latency"}, 32'(lat), 32'(LAT));
    chk({nm, " data"}, 32'(bus.out_data), 32'(exp_d));
    chk({nm, " sticky"}, 32'(bus.out_sticky), 32'(exp_s));
    chk({nm, " tag"}, 32'(bus.out_tag), 32'(tag));
    step();
  endtask

  vec_t        tbl [15];
  exp_t        q [$];
  exp_t        e;
  logic [24:0] m;
  logic [31:0] held;
  logic        stalled;
  int          acc, got, gaps, sent, cyc, stale, held_ok;

  initial begin
    nvec = 0;
    nfail = 0;
    tbl[0]  = '{2'b00, 8'd4,   24'hFFFFFF, 24'h0FFFFF, 1'b1};
    tbl[1]  = '{2'b01, 8'd4,   24'h800010, 24'hF80001, 1'b0};
    tbl[2]  = '{2'b01, 8'd200, 24'h800000, 24'hFFFFFF, 1'b1};
    tbl[3]  = '{2'b10, 8'd23,  24'h000001, 24'h800000, 1'b0};
    tbl[4]  = '{2'b10, 8'd24,  24'h000001, 24'h000000, 1'b0};
    tbl[5]  = '{2'b00, 8'd200, 24'h000001, 24'h000000, 1'b1};
    tbl[6]  = '{2'b00, 8'd0,   24'hABCDEF, 24'hABCDEF, 1'b0};
    tbl[7]  = '{2'b01, 8'd0,   24'h123456, 24'h123456, 1'b0};
    tbl[8]  = '{2'b11, 8'd20,  24'hF00000, 24'h00000F, 1'b0};
    tbl[9]  = '{2'b10, 8'd4,   24'h123456, 24'h234560, 1'b0};
    tbl[10] = '{2'b01, 8'd1,   24'h7FFFFF, 24'h3FFFFF, 1'b1};
    tbl[11] = '{2'b00, 8'd23,  24'h800000, 24'h000001, 1'b0};
    tbl[12] = '{2'b01, 8'd255, 24'h000003, 24'h000000, 1'b1};
    tbl[13] = '{2'b10, 8'd255, 24'hFFFFFF, 24'h000000, 1'b0};
    tbl[14] = '{2'b01, 8'd5,   24'hC00000, 24'hFE0000, 1'b0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_amt = '0;
    bus.in_op = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    #22 rst_n = 1'b1;
    step();

    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_data", 32'(bus.out_data), 32'd0);
    chk("reset out_sticky", 32'(bus.out_sticky), 32'd0);
    chk("reset out_tag", 32'(bus.out_tag), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 15; i++)
      run_vec($sformatf("vec%0d", i), tbl[i].op, tbl[i].amt, tbl[i].d, 4'(i),
              tbl[i].exp_d, tbl[i].exp_s);

    // Backpressure: pipe holds 4, outputs hold still, then drain in order.
    bus.out_ready = 1'b0;
    acc = 0;
    held_ok = 0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (acc < 6);
      bus.in_op = 2'b00;
      bus.in_amt = 8'd8;
      bus.in_data = 24'(acc) << 8;
      bus.in_tag = 4'(acc);
      #1;
      if (bus.out_valid) begin
        if (held_ok != 0)
          chk("bp held stable", {3'b0, bus.out_data, bus.out_sticky, bus.out_tag}, held);
        held = {3'b0, bus.out_data, bus.out_sticky, bus.out_tag};
        held_ok = 1;
      end
      if (bus.in_valid && bus.in_ready) acc++;
      step();
    end
    chk("bp accepts while stalled", 32'(acc), 32'd4);
    #1;
    chk("bp in_ready when full", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    got = 0;
    gaps = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      bus.in_valid = (acc < 6);
      bus.in_data = 24'(acc) << 8;
      bus.in_tag = 4'(acc);
      #1;
      if (bus.out_valid) begin
        chk($sformatf("bp tag %0d", got), 32'(bus.out_tag), 32'(got));
        chk($sformatf("bp data %0d", got), 32'(bus.out_data), 32'(got));
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      if (bus.in_valid && bus.in_ready) acc++;
      step();
    end
    bus.in_valid = 1'b0;
    chk("bp drained count", 32'(got), 32'd6);
    chk("bp drain gaps", 32'(gaps), 32'd0);
    step();
    chk("bp no extra output", 32'(bus.out_valid), 32'd0);

    // Random stream against the reference model.
    sent = 0;
    cyc = 0;
    stalled = 1'b0;
    while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
      bus.in_valid = (sent < 10000) && ($urandom_range(3) != 0);
      bus.in_op = 2'($urandom_range(3));
      bus.in_amt = ($urandom_range(1) != 0) ? 8'($urandom_range(31)) : 8'($urandom_range(255));
      bus.in_data = 24'($urandom);
      bus.in_tag = 4'($urandom);
      bus.out_ready = ($urandom_range(3) != 0);
      #1;
      if (stalled)
        chk("rnd held stable", {2'b0, bus.out_valid, bus.out_data, bus.out_sticky, bus.out_tag},
            {2'b0, 1'b1, held[28:0]});
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("rnd spurious output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rnd result", {3'b0, bus.out_data, bus.out_sticky, bus.out_tag},
              {3'b0, e.d, e.s, e.t});
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = {3'b0, bus.out_data, bus.out_sticky, bus.out_tag};
      if (bus.in_valid && bus.in_ready) begin
        m = model(bus.in_op, bus.in_amt, bus.in_data);
        q.push_back('{m[23:0], m[24], bus.in_tag});
        sent++;
      end
      step();
      cyc++;
    end
    chk("rnd finished in budget", 32'(cyc < 60000), 32'd1);
    chk("rnd beats sent", 32'(sent), 32'd10000);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    step();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op = 2'b00;
      bus.in_amt = 8'd1;
      bus.in_data = 24'h000F00;
      bus.in_tag = 4'(9 + i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    chk("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) stale++;
      step();
    end
    chk("post-reset stale outputs", 32'(stale), 32'd0);
    run_vec("post-reset beat", 2'b01, 8'd8, 24'hF12345, 4'hA, 24'hFFF123, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
